// File: rtl/his_readout.sv
// his_readout: histogram readout engine.
// Scans every bin in ascending order through a read port with one cycle of
// latency. Each bin count is sent on a valid/ready stream. The block also
// tracks the peak bin and the total count.
// Optional feature macro: HIS_RDCLR_EN. When it is defined, each bin is
// written to zero in the cycle after it is read, which leaves the memory
// clear for the next acquisition.
module his_readout #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rdEn,
    output logic [ADDR_W-1:0]       rdAddr,
    input  logic [CNT_W-1:0]        rdData,
    output logic                    clrEn,
    output logic [ADDR_W-1:0]       clrAddr,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [ADDR_W-1:0]       outBin,
    output logic [CNT_W-1:0]        outCount,
    output logic                    outLast,
    output logic [ADDR_W-1:0]       maxBin,
    output logic [CNT_W-1:0]        maxCount,
    output logic [CNT_W+ADDR_W-1:0] totalCount
);

    localparam int TOT_W = CNT_W + ADDR_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;

    // State register.
    always_ff @(posedge clk or posedge res) begin
        if (res) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. A start request is only honoured in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD;
            RD:      state_next = CAP;
            CAP:     state_next = SEND;
            SEND:    if (outReady) state_next = outLast ? DONE : RD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the bin index, the captured beat, and the peak and total trackers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            idx        <= '0;
            outBin     <= '0;
            outCount   <= '0;
            outLast    <= 1'b0;
            maxBin     <= '0;
            maxCount   <= '0;
            totalCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        maxBin     <= '0;
                        maxCount   <= '0;
                        totalCount <= '0;
                    end
                end
                CAP: begin
                    outCount   <= rdData;
                    outBin     <= idx;
                    outLast    <= (idx == {ADDR_W{1'b1}});
                    // The comparison is strict, so the lowest bin wins a tie.
                    if (rdData > maxCount) begin
                        maxCount <= rdData;
                        maxBin   <= idx;
                    end
                    totalCount <= totalCount + TOT_W'(rdData);
                end
                SEND: begin
                    if (outReady && !outLast) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // These strobes decode the registered state only. None of them has a
    // combinational path from an input.
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign rdEn     = (state == RD);
    assign rdAddr   = rdEn ? idx : '0;
    assign outValid = (state == SEND);

`ifdef HIS_RDCLR_EN
    // Clear the bin that was just read. Its data is being captured this cycle.
    assign clrEn   = (state == CAP);
    assign clrAddr = clrEn ? idx : '0;
`else
    assign clrEn   = 1'b0;
    assign clrAddr = '0;
`endif

endmodule

// File: tb/tb_his_readout.sv
// Testbench for his_readout. It holds a behavioural memory with a registered
// read port, drives random stimulus, and checks every scan against a model
// of the scan rules that runs over a copy of the memory contents.
module tb_his_readout;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;
    localparam int NBINS  = 1 << ADDR_W;
    localparam int TOT_W  = CNT_W + ADDR_W;

`ifdef HIS_RDCLR_EN
    localparam bit CLR_MODE = 1'b1;
`else
    localparam bit CLR_MODE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              res = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, rdEn, clrEn, outValid, outLast;
    logic              outReady = 1'b0;
    logic [ADDR_W-1:0] rdAddr, clrAddr, outBin, maxBin;
    logic [CNT_W-1:0]  rdData, outCount, maxCount;
    logic [TOT_W-1:0]  totalCount;

    int total = 0;
    int bad   = 0;

    // Histogram memory with a registered read and a zero-write port.
    logic [CNT_W-1:0] mem      [NBINS];
    logic [CNT_W-1:0] init_mem [NBINS];
    logic [CNT_W-1:0] model    [NBINS];
    logic             load_req = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_req) mem <= init_mem;
        else if (clrEn) mem[clrAddr] <= '0;
        if (rdEn) rdData <= mem[rdAddr];
    end

    his_readout #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .start(start), .busy(busy), .done(done),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData),
        .clrEn(clrEn), .clrAddr(clrAddr),
        .outValid(outValid), .outReady(outReady), .outBin(outBin),
        .outCount(outCount), .outLast(outLast),
        .maxBin(maxBin), .maxCount(maxCount), .totalCount(totalCount)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Load the memory and the model with the same contents.
    task automatic preload(input int mode);
        for (int k = 0; k < NBINS; k++) begin
            case (mode)
                0:       init_mem[k] = CNT_W'(k);
                1:       init_mem[k] = (k == 4 || k == 20) ? 8'd200 : 8'd3;
                default: init_mem[k] = CNT_W'($urandom_range(0, 255));
            endcase
            model[k] = init_mem[k];
        end
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    // Run one scan. It can randomise ready, stall on one bin, issue a second
    // start while busy, or pulse reset when a given bin is being read.
    task automatic run_scan(input string name, input bit rnd_ready, input int stall_bin,
                            input int restart_bin, input int reset_bin, input bit timing);
        logic [ADDR_W-1:0] g_bin [$];
        logic [CNT_W-1:0]  g_cnt [$];
        logic              g_last[$];
        int cyc = 0, done_cnt = 0, stall_cnt = 0;
        bit done_seen = 0, finished = 0, restarted = 0, aborted = 0;
        logic [ADDR_W+CNT_W:0] snap = '0;
        int exp_max_bin = 0, exp_max = 0, exp_tot = 0;

        // Reference: the ascending scan with a strict peak compare and a plain sum.
        for (int k = 0; k < NBINS; k++) begin
            if (int'(model[k]) > exp_max) begin
                exp_max = int'(model[k]);
                exp_max_bin = k;
            end
            exp_tot += int'(model[k]);
        end

        @(negedge clk);
        start = 1'b1;
        while (cyc < 2000 && !finished) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done_seen) begin
                check({name, " busy_after_done"}, busy, 1'b0);
                finished = 1;
                break;
            end
            if (cyc == 1) begin
                check({name, " busy_rise"}, busy, 1'b1);
                if (timing) check({name, " rdEn_cycle1"}, rdEn, 1'b1);
            end
            if (timing && cyc == 2) check({name, " no_valid_cycle2"}, outValid, 1'b0);
            if (timing && cyc == 3) check({name, " valid_cycle3"}, outValid, 1'b1);

            if (reset_bin >= 0 && rdEn && int'(rdAddr) == reset_bin) begin
                #1 res = 1'b1;
                #1;
                check({name, " reset_outputs"},
                      64'({busy, done, rdEn, rdAddr, clrEn, clrAddr, outValid, outBin,
                           outCount, outLast, maxBin, maxCount, totalCount}), 64'd0);
                #1 res = 1'b0;
                aborted = 1;
                break;
            end

            if (stall_bin >= 0 && outValid && int'(outBin) == stall_bin && stall_cnt < 10) begin
                outReady = 1'b0;
                if (stall_cnt == 0) snap = {outBin, outCount, outLast};
                else check({name, " stall_hold"}, 64'({outBin, outCount, outLast}), 64'(snap));
                check({name, " stall_no_rd"}, rdEn, 1'b0);
                stall_cnt++;
            end else begin
                outReady = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end

            if (outValid && outReady) begin
                g_bin.push_back(outBin);
                g_cnt.push_back(outCount);
                g_last.push_back(outLast);
            end

            if (restart_bin >= 0 && !restarted && outValid && int'(outBin) == restart_bin) begin
                start = 1'b1;
                restarted = 1;
            end

            if (done) begin
                done_cnt++;
                if (timing) check({name, " done_latency"}, cyc, 97);
                done_seen = 1;
            end
        end
        outReady = 1'b0;

        if (aborted) begin
            // Bins that reached CAP before the reset have already been cleared.
            if (CLR_MODE) for (int k = 0; k < reset_bin; k++) model[k] = '0;
            $display("scan %s: reset at bin %0d", name, reset_bin);
            return;
        end
        if (!finished) check({name, " timeout"}, 0, 1);

        check({name, " beats"}, g_bin.size(), NBINS);
        check({name, " done_count"}, done_cnt, 1);
        for (int k = 0; k < NBINS && k < g_bin.size(); k++) begin
            check({name, " beat_bin"}, g_bin[k], k);
            check({name, " beat_cnt"}, g_cnt[k], model[k]);
            check({name, " beat_last"}, g_last[k], (k == NBINS - 1));
        end
        check({name, " maxBin"}, maxBin, exp_max_bin);
        check({name, " maxCount"}, maxCount, exp_max);
        check({name, " totalCount"}, totalCount, exp_tot);
        $display("scan %s: beats=%0d maxBin=%0d maxCount=%0d total=%0d cycles=%0d",
                 name, g_bin.size(), maxBin, maxCount, totalCount, cyc);
        if (CLR_MODE) for (int k = 0; k < NBINS; k++) model[k] = '0;
    endtask

    initial begin
        res = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state",
              64'({busy, done, rdEn, rdAddr, clrEn, clrAddr, outValid, outBin,
                   outCount, outLast, maxBin, maxCount, totalCount}), 64'd0);
        res = 1'b0;

        preload(0);
        run_scan("basic", 0, -1, -1, -1, 1);
        check("basic_max_31", maxCount, 31);
        check("basic_total_496", totalCount, 496);
        run_scan("second", 0, -1, -1, -1, 1);

        preload(1);
        run_scan("tie", 0, -1, -1, -1, 1);
        check("tie_maxBin_4", maxBin, 4);
        check("tie_total_490", totalCount, 490);

        preload(0);
        run_scan("backpressure", 1, 7, -1, -1, 0);

        preload(2);
        run_scan("start_busy", 1, -1, 12, -1, 0);

        preload(2);
        run_scan("reset_mid", 0, -1, -1, 10, 0);
        for (int k = 0; k < NBINS; k++) check("mem_after_reset", mem[k], model[k]);
        run_scan("rescan", 1, -1, -1, -1, 0);

        preload(2);
        run_scan("random", 1, -1, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
